scan_mux: RTL and testbench
===========================

# scan_mux

Registered, parametrised N-channel × WIDTH-bit multiplexer with an active-high output disable. It supports two modes: manual select, and an automatic round-robin scan that holds each channel for a programmable dwell time. It sits between parallel data sources and a single downstream consumer, such as a display digit driver or a shared bus. It adds a registered output, a channel indicator, a valid flag and a scan-wrap pulse.

## Interface
Parameters:
- WIDTH, default 4: bits per channel.
- CHANNELS, default 4: number of input channels; must be ≥2.
- DWELL, default 8: cycles each channel is held in scan mode; must be ≥1.
- SELW, derived as $clog2(CHANNELS): select width.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- D, input, CHANNELS*WIDTH: flattened data; channel k is D[k*WIDTH +: WIDTH].
- S, input, SELW: manual channel select.
- M, input, 1: mode; 0 = manual, 1 = scan.
- E, input, 1: active-high disable; forces out to 0.
- out, output, WIDTH: registered selected data.
- ch, output, SELW: channel currently presented on out.
- valid, output, 1: out carries real channel data.
- wrap, output, 1: one-cycle pulse when scan advances from CHANNELS-1 to 0.

## Operation
- Each cycle the block computes a next channel nch, then registers ch ← nch and out ← D[nch]. out and ch always describe the same channel.
- Manual mode (M=0):
  - nch = S.
  - If S ≥ CHANNELS: out ← 0, valid ← 0, and ch ← S is still registered.
  - The dwell counter is held at 0.
- Scan mode (M=1): the dwell counter cnt runs from 0 to DWELL-1.
  - While cnt < DWELL-1: nch = ch and cnt increments.
  - When cnt = DWELL-1: cnt ← 0 and nch = ch+1.
  - When advancing from ch = CHANNELS-1, nch = 0 and wrap ← 1 for that cycle.
- Entering scan mode (M = 1 this cycle, 0 the previous cycle):
  - cnt restarts at 0.
  - Scanning starts from the current ch. If ch ≥ CHANNELS, nch = 0.
- Disable (E=1) has priority over mode:
  - out ← 0, valid ← 0, wrap ← 0.
  - ch and cnt freeze at their current values.
  - When E drops, operation resumes from the frozen state with no cycle skipped.
- valid = 1 whenever E=0 and the selected channel is in range.
- Simultaneous events:
  - rst beats E, and E beats M.
  - A change of M in the same cycle as a dwell expiry follows the new mode.

## Timing
- Reset values: out=0, ch=0, valid=0, wrap=0, cnt=0, prev-M register=0.
- Latency from D, S or E to out/valid is 1 cycle. There is no combinational path from inputs to outputs.
- In scan mode each channel is presented for exactly DWELL consecutive cycles.
- A full scan period is CHANNELS×DWELL cycles.
- wrap pulses once per period, in the first cycle that ch=0 is presented.
- DWELL=1 advances the channel every cycle.
- rst asserted mid-scan: the next edge restores the reset values. Scanning, if M=1, then restarts from channel 0 with cnt=0.

## Structure
- Package scan_mux_pkg holds:
  - Mode constants MODE_MANUAL=1'b0 and MODE_SCAN=1'b1.
  - Helper function sel_width(n) returning $clog2(n).
- Sub-module scan_sequencer holds the dwell counter, channel advance, mode-entry detection, freeze-on-E logic and wrap generation. It outputs nch and wrap_next.
- The top level contains the data select, range check and output registers.

## Test plan
All scenarios use WIDTH=4, CHANNELS=4, DWELL=3, and D = channels {0:A, 1:B, 2:C, 3:D} in hex.
- Reset: hold rst 2 cycles with M=1 and E=0 → out=0, ch=0, valid=0, wrap=0. On the first cycle after release, out=A and valid=1.
- Manual mode: M=0, apply S=2 then S=1 on consecutive cycles → out=C, then out=B, each one cycle after its S. ch tracks S.
- Scan sequence: M=1 for 14 cycles → out sequence A,A,A,B,B,B,C,C,C,D,D,D,A,A. wrap is high only on the 13th output, the first return to A.
- Disable mid-scan: assert E=1 for 4 cycles on the second B → out=0 and valid=0 for those 4 cycles. After release, exactly one more B is presented, then C.
- Mode entry: M=0 with S=3, then set M=1 → D is presented for 3 cycles, then A with wrap=1.
- Reset mid-scan and out-of-range select:
  - Assert rst while presenting C → out=0 next cycle, then A.
  - Separately, with CHANNELS=3 and M=0, S=3 → out=0 and valid=0.

Source files
------------

// File: rtl/scan_mux_pkg.sv
// Shared constants and helpers for the scan_mux channel multiplexer.
package scan_mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    function automatic int unsigned sel_width(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/scan_sequencer.sv
// Dwell counter and channel advance for scan_mux; produces the next channel and the wrap pulse.
module scan_sequencer
    import scan_mux_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DWELL    = 8,
    parameter int unsigned SELW     = sel_width(CHANNELS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m,
    input  logic            e,
    input  logic [SELW-1:0] s,
    input  logic [SELW-1:0] ch,
    output logic [SELW-1:0] nch,
    output logic            wrap_next
);

    localparam int unsigned CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);
    localparam logic [SELW-1:0] CH_LAST  = SELW'(CHANNELS - 1);

    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            prev_m_q, prev_m_d;
    logic [31:0]     ch_ext;
    logic            ch_in_range;

    assign ch_ext      = 32'(ch);
    assign ch_in_range = ch_ext < CHANNELS;

    always_comb begin
        nch       = ch;
        wrap_next = 1'b0;
        cnt_d     = cnt_q;
        prev_m_d  = prev_m_q;
        // While disabled everything holds, including the mode history, so a
        // mode entry made under disable is still seen once it drops.
        if (!e) begin
            prev_m_d = m;
            if (m == MODE_MANUAL) begin
                nch   = s;
                cnt_d = '0;
            end else if (prev_m_q == MODE_MANUAL) begin
                cnt_d = '0;
                nch   = ch_in_range ? ch : '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                if (ch == CH_LAST || !ch_in_range) begin
                    nch       = '0;
                    wrap_next = (ch == CH_LAST);
                end else begin
                    nch = ch + 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            prev_m_q <= MODE_MANUAL;
        end else begin
            cnt_q    <= cnt_d;
            prev_m_q <= prev_m_d;
        end
    end

endmodule

// File: rtl/scan_mux.sv
// Registered N-channel multiplexer with manual select, timed round-robin scan and output disable.
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DWELL    = 8,
    parameter int unsigned SELW     = sel_width(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] D,
    input  logic [SELW-1:0]           S,
    input  logic                      M,
    input  logic                      E,
    output logic [WIDTH-1:0]          out,
    output logic [SELW-1:0]           ch,
    output logic                      valid,
    output logic                      wrap
);

    logic [SELW-1:0]  nch;
    logic             wrap_next;
    logic [31:0]      nch_ext;
    logic             valid_d;
    logic [WIDTH-1:0] sel_data;

    scan_sequencer #(
        .CHANNELS (CHANNELS),
        .DWELL    (DWELL),
        .SELW     (SELW)
    ) u_seq (
        .clk       (clk),
        .rst       (rst),
        .m         (M),
        .e         (E),
        .s         (S),
        .ch        (ch),
        .nch       (nch),
        .wrap_next (wrap_next)
    );

    assign nch_ext = 32'(nch);
    assign valid_d = !E && (nch_ext < CHANNELS);

    // Compare-and-pick keeps the part-select in bounds for non power-of-two channel counts.
    always_comb begin
        sel_data = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (nch_ext == k) begin
                sel_data = D[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out   <= '0;
            ch    <= '0;
            valid <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            ch    <= nch;
            valid <= valid_d;
            out   <= valid_d ? sel_data : '0;
            wrap  <= wrap_next;
        end
    end

endmodule

// File: tb/tb_scan_mux.sv
// Directed bench for scan_mux: reset, scan timing, disable, mode entry, manual and range checks.
module tb_scan_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, M, E, M1, E1;
    logic [1:0]  S, S1;
    logic [15:0] D  = 16'hDCBA;
    logic [11:0] D1 = 12'hCBA;

    logic [3:0] out0, out1, out2;
    logic [1:0] ch0, ch1, ch2;
    logic       valid0, valid1, valid2, wrap0, wrap1, wrap2;

    int checks   = 0;
    int failures = 0;

    scan_mux #(.WIDTH(4), .CHANNELS(4), .DWELL(3)) dut0 (
        .clk(clk), .rst(rst), .D(D), .S(S), .M(M), .E(E),
        .out(out0), .ch(ch0), .valid(valid0), .wrap(wrap0)
    );

    scan_mux #(.WIDTH(4), .CHANNELS(3), .DWELL(3)) dut1 (
        .clk(clk), .rst(rst), .D(D1), .S(S1), .M(M1), .E(E1),
        .out(out1), .ch(ch1), .valid(valid1), .wrap(wrap1)
    );

    scan_mux #(.WIDTH(4), .CHANNELS(4), .DWELL(1)) dut2 (
        .clk(clk), .rst(rst), .D(D), .S(S), .M(M), .E(E),
        .out(out2), .ch(ch2), .valid(valid2), .wrap(wrap2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] seq [14] = '{4'hA, 4'hA, 4'hA, 4'hB, 4'hB, 4'hB, 4'hC,
                             4'hC, 4'hC, 4'hD, 4'hD, 4'hD, 4'hA, 4'hA};

    initial begin
        rst = 1'b1; M = 1'b1; E = 1'b0; S = 2'd0;
        M1 = 1'b0; E1 = 1'b0; S1 = 2'd0;
        tick();
        tick();
        check_eq("rst_out",   32'(out0),   32'h0);
        check_eq("rst_ch",    32'(ch0),    32'h0);
        check_eq("rst_valid", 32'(valid0), 32'h0);
        check_eq("rst_wrap",  32'(wrap0),  32'h0);

        rst = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            check_eq($sformatf("scan_out%0d", i),  32'(out0),  32'(seq[i]));
            check_eq($sformatf("scan_wrap%0d", i), 32'(wrap0), (i == 12) ? 32'h1 : 32'h0);
            check_eq($sformatf("scan_valid%0d", i), 32'(valid0), 32'h1);
            check_eq($sformatf("d1_out%0d", i),  32'(out2),  32'(4'hA + 4'(i % 4)));
            check_eq($sformatf("d1_wrap%0d", i), 32'(wrap2), (i > 0 && i % 4 == 0) ? 32'h1 : 32'h0);
        end

        tick(); check_eq("pre_dis_a",  32'(out0), 32'hA);
        tick(); check_eq("pre_dis_b1", 32'(out0), 32'hB);
        tick(); check_eq("pre_dis_b2", 32'(out0), 32'hB);

        E = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq($sformatf("dis_out%0d", i),   32'(out0),   32'h0);
            check_eq($sformatf("dis_valid%0d", i), 32'(valid0), 32'h0);
            check_eq($sformatf("dis_ch%0d", i),    32'(ch0),    32'h1);
            check_eq($sformatf("dis_wrap%0d", i),  32'(wrap0),  32'h0);
        end
        E = 1'b0;
        tick(); check_eq("resume_b", 32'(out0), 32'hB);
        check_eq("resume_valid", 32'(valid0), 32'h1);
        tick(); check_eq("resume_c1", 32'(out0), 32'hC);
        tick(); check_eq("resume_c2", 32'(out0), 32'hC);

        rst = 1'b1;
        tick();
        check_eq("midrst_out", 32'(out0), 32'h0);
        check_eq("midrst_ch",  32'(ch0),  32'h0);
        rst = 1'b0;
        tick(); check_eq("midrst_restart", 32'(out0), 32'hA);

        M = 1'b0; S = 2'd2;
        tick(); check_eq("man_s2_out", 32'(out0), 32'hC);
        check_eq("man_s2_ch", 32'(ch0), 32'h2);
        S = 2'd1;
        tick(); check_eq("man_s1_out", 32'(out0), 32'hB);
        check_eq("man_s1_ch", 32'(ch0), 32'h1);

        S = 2'd3;
        tick(); check_eq("entry_man_d", 32'(out0), 32'hD);
        M = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("entry_d%0d", i),    32'(out0),  32'hD);
            check_eq($sformatf("entry_wrap%0d", i), 32'(wrap0), 32'h0);
        end
        tick();
        check_eq("entry_a",    32'(out0),  32'hA);
        check_eq("entry_wrap", 32'(wrap0), 32'h1);

        S1 = 2'd2;
        tick();
        check_eq("c3_s2_out",   32'(out1),   32'hC);
        check_eq("c3_s2_valid", 32'(valid1), 32'h1);
        S1 = 2'd3;
        tick();
        check_eq("c3_oor_out",   32'(out1),   32'h0);
        check_eq("c3_oor_valid", 32'(valid1), 32'h0);
        check_eq("c3_oor_ch",    32'(ch1),    32'h3);
        S1 = 2'd1; E1 = 1'b1;
        tick();
        check_eq("c3_dis_out", 32'(out1), 32'h0);
        check_eq("c3_dis_ch",  32'(ch1),  32'h3);
        E1 = 1'b0;
        tick();
        check_eq("c3_s1_out", 32'(out1), 32'hB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
